// File: rtl/sng_scheduler.sv
// rtl/sng_scheduler.sv - two-requester round-robin stochastic number generator scheduler (optional SNG_RESEED_EN: reseed LFSR on grant)
module sng_scheduler #(
    parameter int LEN_WIDTH = 8,
    parameter int NUM_REQ   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7:0]           req_value0,
    input  logic [7:0]           req_value1,
    input  logic [LEN_WIDTH-1:0] req_len0,
    input  logic [LEN_WIDTH-1:0] req_len1,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [7:0]           seed,
    output logic                 bit_valid,
    output logic                 sc_bit,
    output logic                 bit_owner,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] ones_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [7:0]           value_q, value_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] ones_q, ones_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;

    logic                 winner;
    logic [7:0]           lfsr_next;
    logic [LEN_WIDTH-1:0] len_sel;
    logic [7:0]           value_sel;

`ifndef SNG_RESEED_EN
    // Seed only matters when reseeding is built in.
    logic seed_unused;
    assign seed_unused = ^seed;
`endif

    // Fibonacci LFSR step, taps 8,6,5,4; never reaches zero from a nonzero state.
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        winner = req_valid[1];
        if (req_valid[0] && req_valid[1]) begin
            winner = ~last_q;
        end
    end

    assign len_sel   = winner ? req_len1 : req_len0;
    assign value_sel = winner ? req_value1 : req_value0;

    // Next-state and output decode for the IDLE/RUN/DONE job sequencer.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        value_d   = value_q;
        rem_d     = rem_q;
        ones_d    = ones_q;
        owner_d   = owner_q;
        last_d    = last_q;
        req_ready = '0;
        bit_valid = 1'b0;
        sc_bit    = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && !rst) begin
                    req_ready[winner] = 1'b1;
                    value_d = value_sel;
                    rem_d   = len_sel;
                    owner_d = winner;
                    ones_d  = '0;
`ifdef SNG_RESEED_EN
                    lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
`endif
                    state_d = (len_sel == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                bit_valid = 1'b1;
                sc_bit    = (lfsr_q < value_q);
                ones_d    = ones_q + {{(LEN_WIDTH-1){1'b0}}, sc_bit};
                lfsr_d    = lfsr_next;
                rem_d     = rem_q - 1'b1;
                if (rem_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= 8'h01;
            value_q <= 8'h00;
            rem_q   <= '0;
            ones_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            value_q <= value_d;
            rem_q   <= rem_d;
            ones_q  <= ones_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign ones_count = ones_q;
    assign bit_owner  = owner_q;

endmodule

// File: tb/tb_sng_scheduler.sv
// tb/tb_sng_scheduler.sv - directed self-checking bench for sng_scheduler
module tb_sng_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_value0, req_value1;
    logic [7:0] req_len0, req_len1;
    logic [1:0] req_ready;
    logic [7:0] seed;
    logic       bit_valid, sc_bit, bit_owner, done;
    logic [7:0] ones_count;

    int n_vec = 0;
    int n_err = 0;

    int got_bits[$];
    int exp_bits[$];

    sng_scheduler #(.LEN_WIDTH(8), .NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_value0 (req_value0),
        .req_value1 (req_value1),
        .req_len0   (req_len0),
        .req_len1   (req_len1),
        .req_ready  (req_ready),
        .seed       (seed),
        .bit_valid  (bit_valid),
        .sc_bit     (sc_bit),
        .bit_owner  (bit_owner),
        .done       (done),
        .ones_count (ones_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic build_exp(input logic [7:0] start, input int skip, input int n, input logic [7:0] v);
        logic [7:0] s;
        s = start;
        exp_bits.delete();
        for (int i = 0; i < skip; i++) s = lfsr_nxt(s);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back((s < v) ? 1 : 0);
            s = lfsr_nxt(s);
        end
    endtask

    task automatic compare_bits(input string tag);
        int mism;
        mism = 0;
        check({tag, "_len"}, got_bits.size(), exp_bits.size());
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
            if (got_bits[i] != exp_bits[i]) mism++;
        check({tag, "_bits"}, mism, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Runs one job from request to the cycle after done; leaves time at a sample point.
    task automatic do_job(input logic [1:0] vld, input bit hold, output int owner,
                          output int wait_cyc, output int dcyc, output int ones);
        bit found;
        bit done_seen;
        int own_err;
        int sc_err;
        got_bits.delete();
        owner = -1; wait_cyc = 0; dcyc = 0; ones = -1;
        own_err = 0; sc_err = 0;
        found = 1'b0; done_seen = 1'b0;
        req_valid = vld;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (req_ready != 2'b00) found = 1'b1;
            else begin
                wait_cyc++;
                step();
            end
        end
        check("ready_seen", found, 1);
        if (!found) return;
        check("ready_onehot", $onehot(req_ready), 1);
        owner = req_ready[1];
        step();
        if (!hold) req_valid = 2'b00;
        #1;
        check("ready_pulse", req_ready, 0);
        for (int i = 0; i < 400 && !done_seen; i++) begin
            dcyc++;
            if (bit_valid) begin
                got_bits.push_back(sc_bit);
                if (bit_owner != owner[0]) own_err++;
            end else if (sc_bit) begin
                sc_err++;
            end
            if (done) begin
                done_seen = 1'b1;
                ones = ones_count;
            end
            step();
        end
        check("done_seen", done_seen, 1);
        check("owner_during_run", own_err, 0);
        check("sc_bit_idle_zero", sc_err, 0);
        check("ones_hold", ones_count, ones);
    endtask

    initial begin
        int owner, wait_cyc, dcyc, ones, cnt, dn;
        rst = 1'b1;
        req_valid = 2'b00;
        req_value0 = 8'd0; req_value1 = 8'd0;
        req_len0 = 8'd0;   req_len1 = 8'd0;
        seed = 8'h00;

        do_reset();
        check("rst_req_ready", req_ready, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_sc_bit", sc_bit, 0);
        check("rst_done", done, 0);
        check("rst_ones", ones_count, 0);
        check("rst_owner", bit_owner, 0);

        // Full LFSR period at threshold 128
        req_value0 = 8'd128; req_len0 = 8'd255;
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
        check("p255_owner", owner, 0);
        check("p255_nbits", got_bits.size(), 255);
        check("p255_ones", ones, 127);
        check("p255_latency", dcyc, 256);
        build_exp(8'h01, 0, 255, 8'd128);
        compare_bits("p255");

        // Threshold 0: never a one
        do_reset();
        req_value0 = 8'd0; req_len0 = 8'd20;
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
        check("v0_nbits", got_bits.size(), 20);
        check("v0_ones", ones, 0);

        // Threshold 255 via requester 1 alone
        do_reset();
        req_value1 = 8'd255; req_len1 = 8'd255;
        do_job(2'b10, 0, owner, wait_cyc, dcyc, ones);
        check("v255_owner", owner, 1);
        check("v255_ones", ones, 254);

        // Zero-length job
        do_reset();
        req_value0 = 8'd200; req_len0 = 8'd0;
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
        check("len0_nbits", got_bits.size(), 0);
        check("len0_done_latency", dcyc, 1);
        check("len0_ones", ones, 0);

        // Round robin with both requesters held
        do_reset();
        req_value0 = 8'd128; req_value1 = 8'd128;
        req_len0 = 8'd3; req_len1 = 8'd3;
        for (int j = 0; j < 4; j++) begin
            do_job(2'b11, 1, owner, wait_cyc, dcyc, ones);
            check($sformatf("rr_owner%0d", j), owner, j % 2);
            check($sformatf("rr_wait%0d", j), wait_cyc, 0);
            check($sformatf("rr_nbits%0d", j), got_bits.size(), 3);
        end
        req_valid = 2'b00;

        // Reset on the 5th RUN cycle of a len-10 job
        do_reset();
        req_value0 = 8'd128; req_len0 = 8'd10;
        req_valid = 2'b01;
        cnt = 0;
        for (int i = 0; i < 20 && req_ready == 2'b00; i++) step();
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 20 && cnt < 5; i++) begin
            if (bit_valid) cnt++;
            if (cnt < 5) step();
        end
        check("midrun_cycles", cnt, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (done || bit_valid) dn++;
            step();
        end
        check("midrun_no_done", dn, 0);
        req_len0 = 8'd8;
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
        build_exp(8'h01, 0, 8, 8'd128);
        compare_bits("midrun_next");

        // Two len-8 jobs: LFSR continuation (or reseed when built in)
        do_reset();
        seed = 8'hA5;
        req_value0 = 8'd128; req_len0 = 8'd8;
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
`ifdef SNG_RESEED_EN
        build_exp(8'hA5, 0, 8, 8'd128);
`else
        build_exp(8'h01, 0, 8, 8'd128);
`endif
        compare_bits("seq_job1");
        do_job(2'b01, 0, owner, wait_cyc, dcyc, ones);
`ifdef SNG_RESEED_EN
        build_exp(8'hA5, 0, 8, 8'd128);
`else
        build_exp(8'h01, 8, 8, 8'd128);
`endif
        compare_bits("seq_job2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
